// File: rtl/ones_count_accumulator_pkg.sv
// Shared types and helpers for the ones-count frame accumulator.
package ones_count_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Popcount of a w-bit word needs enough bits to represent w itself.
  function automatic int pc_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/ones_count_function.sv
// Combinational popcount of one inCount-bit word.
module ones_count_function
  import ones_count_accumulator_pkg::*;
#(
  parameter int inCount = 16
) (
  input  logic [inCount-1:0]           in_vec,
  output logic [pc_width(inCount)-1:0] count
);

  localparam int PC_W = pc_width(inCount);

  always_comb begin
    count = '0;
    for (int i = 0; i < inCount; i++) begin
      count = count + PC_W'(in_vec[i]);
    end
  end

endmodule

// File: rtl/ones_count_accumulator.sv
// Accumulates per-word popcounts over a frame and hands the saturated
// frame total and word count downstream over a valid/ready handshake.
module ones_count_accumulator
  import ones_count_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_vec,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic [ACC_WIDTH-1:0] word_cnt,
  output logic                 sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int PC_W = pc_width(IN_WIDTH);

  // Top bit of the result is the carry-out; the value clamps when it is set.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[ACC_WIDTH]) begin
      s = {1'b1, {ACC_WIDTH{1'b1}}};
    end
    return s;
  endfunction

  logic [PC_W-1:0]      pc;
  state_t               state_reg, state_next;
  logic [ACC_WIDTH-1:0] acc_sum_reg, acc_cnt_reg;
  logic                 acc_sat_reg;
  logic [ACC_WIDTH-1:0] sum_reg, word_cnt_reg;
  logic                 sat_reg;
  logic [ACC_WIDTH:0]   add_sum, add_cnt;
  logic                 sat_next;
  logic                 accept;

  ones_count_function #(
    .inCount(IN_WIDTH)
  ) u_ones_count (
    .in_vec(in_vec),
    .count (pc)
  );

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == HOLD);
  assign accept    = in_valid && in_ready;

  assign add_sum  = sat_add(acc_sum_reg, ACC_WIDTH'(pc));
  assign add_cnt  = sat_add(acc_cnt_reg, ACC_WIDTH'(1));
  assign sat_next = acc_sat_reg | add_sum[ACC_WIDTH] | add_cnt[ACC_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && in_last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Last word folds into the published result while the accumulators restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum_reg  <= '0;
      acc_cnt_reg  <= '0;
      acc_sat_reg  <= 1'b0;
      sum_reg      <= '0;
      word_cnt_reg <= '0;
      sat_reg      <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        sum_reg      <= add_sum[ACC_WIDTH-1:0];
        word_cnt_reg <= add_cnt[ACC_WIDTH-1:0];
        sat_reg      <= sat_next;
        acc_sum_reg  <= '0;
        acc_cnt_reg  <= '0;
        acc_sat_reg  <= 1'b0;
      end else begin
        acc_sum_reg  <= add_sum[ACC_WIDTH-1:0];
        acc_cnt_reg  <= add_cnt[ACC_WIDTH-1:0];
        acc_sat_reg  <= sat_next;
      end
    end
  end

  assign sum      = sum_reg;
  assign word_cnt = word_cnt_reg;
  assign sat      = sat_reg;

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Drives one word stream into a 16-bit and a 5-bit accumulator and checks
// both against a frame-level arithmetic model.
module tb_ones_count_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_vec;
  logic        in_valid, in_last, out_ready;

  logic        in_ready16, out_valid16, sat16;
  logic [15:0] sum16, cnt16;
  logic        in_ready5, out_valid5, sat5;
  logic [4:0]  sum5, cnt5;

  int checks = 0;
  int errors = 0;
  int m_total = 0;
  int m_count = 0;

  always #5 clk = ~clk;

  ones_count_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready16), .sum(sum16), .word_cnt(cnt16), .sat(sat16),
    .out_valid(out_valid16), .out_ready(out_ready)
  );

  ones_count_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready5), .sum(sum5), .word_cnt(cnt5), .sat(sat5),
    .out_valid(out_valid5), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int sat_exp(input int w);
    int mx;
    mx = (1 << w) - 1;
    return ((m_total > mx) || (m_count > mx)) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_ovalid16"}, out_valid16, 1);
    chk({tag, "_ovalid5"},  out_valid5,  1);
    chk({tag, "_iready16"}, in_ready16,  0);
    chk({tag, "_sum16"},    sum16, clamp(m_total, 16));
    chk({tag, "_cnt16"},    cnt16, clamp(m_count, 16));
    chk({tag, "_sat16"},    sat16, sat_exp(16));
    chk({tag, "_sum5"},     sum5,  clamp(m_total, 5));
    chk({tag, "_cnt5"},     cnt5,  clamp(m_count, 5));
    chk({tag, "_sat5"},     sat5,  sat_exp(5));
    $display("frame %s words=%0d ones=%0d sum16=%0d sum5=%0d sat5=%0b",
             tag, m_count, m_total, sum16, sum5, sat5);
    m_total = 0;
    m_count = 0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit last, input string tag);
    int n;
    n = 0;
    in_vec = w;
    in_valid = 1'b1;
    in_last = last;
    while (in_ready16 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready16 !== 1'b1) chk({tag, "_ready_timeout"}, in_ready16, 1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    m_total += $countones(w);
    m_count++;
    if (last) check_result(tag);
  endtask

  task automatic recv(input int delay, input string tag);
    logic [15:0] s;
    s = sum16;
    out_ready = 1'b0;
    for (int i = 0; i < delay; i++) tick();
    chk({tag, "_hold_valid"}, out_valid16, 1);
    chk({tag, "_hold_sum"},   sum16, s);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_done_valid16"}, out_valid16, 0);
    chk({tag, "_done_valid5"},  out_valid5,  0);
    chk({tag, "_done_ready16"}, in_ready16,  1);
    chk({tag, "_done_ready5"},  in_ready5,   1);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] held_sum;
    int len;
    rst = 1'b1;
    in_vec = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state.
    chk("rst_iready", in_ready16, 1);
    chk("rst_ovalid", out_valid16, 0);
    chk("rst_sum", sum16, 0);
    chk("rst_cnt", cnt16, 0);
    chk("rst_sat", sat16, 0);
    chk("rst_ovalid5", out_valid5, 0);

    // Basic three-word frame.
    send_word(16'hFFFF, 1'b0, "f1");
    send_word(16'h0F0F, 1'b0, "f1");
    send_word(16'h0001, 1'b1, "f1");
    chk("f1_sum_const", sum16, 25);
    chk("f1_cnt_const", cnt16, 3);
    recv(0, "f1");

    // Single-word frame.
    send_word(16'h8001, 1'b1, "single");
    chk("single_sum_const", sum16, 2);
    chk("single_cnt_const", cnt16, 1);
    recv(1, "single");

    // Backpressure: next word waits while the result is held.
    send_word(16'h1234, 1'b1, "bp");
    held_sum = sum16;
    in_vec = 16'h00F0;
    in_valid = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_iready", in_ready16, 0);
      chk("bp_ovalid", out_valid16, 1);
      chk("bp_sum_stable", sum16, held_sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ovalid", out_valid16, 0);
    chk("bp_release_iready", in_ready16, 1);
    send_word(16'h00F0, 1'b0, "bp2");
    send_word(16'h0000, 1'b1, "bp2");
    chk("bp2_sum_const", sum16, 4);
    chk("bp2_cnt_const", cnt16, 2);
    recv(0, "bp2");

    // Sum saturation in the 5-bit instance, then a clean frame.
    send_word(16'hFFFF, 1'b0, "satf");
    send_word(16'hFFFF, 1'b0, "satf");
    send_word(16'hFFFF, 1'b1, "satf");
    chk("satf_sum5_const", sum5, 31);
    chk("satf_sat5_const", sat5, 1);
    chk("satf_cnt5_const", cnt5, 3);
    recv(0, "satf");
    send_word(16'h0003, 1'b1, "after_sat");
    chk("after_sat_sum5_const", sum5, 2);
    chk("after_sat_sat5_const", sat5, 0);
    recv(0, "after_sat");

    // Word-count saturation with all-zero words.
    for (int i = 0; i < 33; i++) send_word(16'h0000, i == 32, "cntsat");
    chk("cntsat_cnt5_const", cnt5, 31);
    recv(0, "cntsat");

    // Asynchronous reset mid-frame discards the partial frame.
    send_word(16'hAAAA, 1'b0, "abort");
    send_word(16'h5555, 1'b0, "abort");
    #2;
    rst = 1'b1;
    #1;
    chk("abort_sum_cleared", sum16, 0);
    chk("abort_iready", in_ready16, 1);
    chk("abort_ovalid", out_valid16, 0);
    m_total = 0;
    m_count = 0;
    tick();
    rst = 1'b0;
    tick();
    chk("abort_no_output", out_valid16, 0);
    send_word(16'h00FF, 1'b1, "post_abort");
    chk("post_abort_sum_const", sum16, 8);
    chk("post_abort_cnt_const", cnt16, 1);
    recv(0, "post_abort");

    // Randomized frames with idle gaps, stray in_last and out_ready in ACCUM.
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          in_valid = 1'b0;
          in_last = 1'($urandom);
          in_vec = 16'($urandom);
          out_ready = 1'($urandom);
          tick();
          chk("rnd_gap_ovalid", out_valid16, 0);
        end
        out_ready = 1'b0;
        in_last = 1'b0;
        w = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
        send_word(w, i == len - 1, "rnd");
      end
      recv($urandom_range(0, 3), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
